// File: rtl/uart_rx_pkg.sv
// Shared constants, types and helpers for the UART receive buffer.
// Optional error counters are enabled by defining UART_RX_ERR_CNT_EN.
package uart_rx_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_AW         = $clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W      = 8;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  typedef logic [DEF_AW:0]      ptr_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Increment that sticks at all-ones.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port, one
// asynchronous read port, no reset (contents are don't-care until written).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data
module uart_rx_fifo_mem
  import uart_rx_pkg::*;
#(
  parameter  int unsigned DW    = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART RX frame FSM. Captures one byte per good
// frame on the rising edge of data_valid, holds up to DEPTH bytes and
// presents them on a first-word-fall-through valid/ready port. A byte
// arriving while full (with no pop) is dropped and sets a sticky overflow.
// Optional macro UART_RX_ERR_CNT_EN adds saturating parity/stop error
// counters; without it the counter outputs are tied to zero.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   p_data, data_valid  deserializer byte and frame-good level
//   par_err, stp_err    parity / stop error levels (counters only)
//   flush               synchronous empty request
//   rd_ready            consumer accepts rd_data
//   rd_valid, rd_data   FIFO head
//   count, full         occupancy 0..DEPTH, count==DEPTH
//   overflow, ovf_clr   sticky drop flag and its clear
//   par_err_cnt, stp_err_cnt  error frame counters
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_err,
  input  logic                  stp_err,
  input  logic                  flush,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [CNT_W-1:0]      par_err_cnt,
  output logic [CNT_W-1:0]      stp_err_cnt
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          dv_q;
  logic          push, pop, wr_en, ovf_set;
  logic          full_nxt, rd_valid_nxt;

  // Next pointer/occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    push       = data_valid & ~dv_q;
    pop        = rd_valid & rd_ready;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      // A pop in the same cycle frees the slot the push needs.
      wr_en   = push & (~full | pop);
      ovf_set = push & full & ~pop;
      if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
      if (pop)   rd_ptr_nxt = rd_ptr + PW'(1);
      count_nxt = count + PW'(wr_en) - PW'(pop);
    end
    rd_valid_nxt = (wr_ptr_nxt != rd_ptr_nxt);
    full_nxt     = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                   (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  end

  // Pointers, flags and edge-detect register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= rd_valid_nxt;
      full     <= full_nxt;
      dv_q     <= data_valid;
      // A drop in the same cycle as a clear keeps the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  uart_rx_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (p_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef UART_RX_ERR_CNT_EN
  logic par_q, stp_q;

  // Count error frames on the rising edge of each error level; clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q       <= 1'b0;
      stp_q       <= 1'b0;
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else begin
      par_q <= par_err;
      stp_q <= stp_err;
      if (ovf_clr) begin
        par_err_cnt <= '0;
        stp_err_cnt <= '0;
      end else begin
        if (par_err & ~par_q) par_err_cnt <= sat_inc(par_err_cnt);
        if (stp_err & ~stp_q) stp_err_cnt <= sat_inc(stp_err_cnt);
      end
    end
  end
`else
  logic unused_err;
  assign unused_err  = par_err ^ stp_err;
  assign par_err_cnt = '0;
  assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int unsigned D = DEF_DEPTH;

  logic       clk, rst_n;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, flush, rd_ready, ovf_clr;
  logic       rd_valid, full, overflow;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic [7:0] par_err_cnt, stp_err_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit m_ovf, m_dvq, m_pq, m_sq;
  int m_pc, m_sc;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .flush       (flush),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the buffer rules to a queue on each clock edge.
  always @(posedge clk) begin
    bit psh, pp, was_full, set;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_dvq = 0; m_pq = 0; m_sq = 0; m_pc = 0; m_sc = 0;
    end else begin
      psh      = data_valid && !m_dvq;
      pp       = (mq.size() > 0) && rd_ready;
      was_full = (mq.size() == D);
      set      = 0;
      if (flush) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (psh) begin
          if (was_full && !pp) set = 1;
          else mq.push_back(p_data);
        end
      end
      if (set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_dvq = data_valid;
`ifdef UART_RX_ERR_CNT_EN
      if (ovf_clr) begin
        m_pc = 0; m_sc = 0;
      end else begin
        if (par_err && !m_pq && m_pc < 255) m_pc++;
        if (stp_err && !m_sq && m_sc < 255) m_sc++;
      end
`endif
      m_pq = par_err;
      m_sq = stp_err;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      chk("m_full", 32'(full), 32'(mq.size() == D));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(mq[0]));
      chk("m_par_cnt", 32'(par_err_cnt), 32'(m_pc));
      chk("m_stp_cnt", 32'(stp_err_cnt), 32'(m_sc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input int len);
    p_data = b;
    data_valid = 1'b1;
    repeat (len) step();
    data_valid = 1'b0;
    step();
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < int'(D); i++) frame(base + 8'(i), 1);
  endtask

  initial begin
    rst_n = 0; p_data = 0; data_valid = 0; par_err = 0; stp_err = 0;
    flush = 0; rd_ready = 0; ovf_clr = 0;
    step();
    run = 1;
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1;
    step();

    // 1: long data_valid pushes once
    p_data = 8'hA5; data_valid = 1;
    step();
    chk("t1_rd_valid", 32'(rd_valid), 1);
    chk("t1_rd_data", 32'(rd_data), 32'hA5);
    chk("t1_count", 32'(count), 1);
    repeat (4) step();
    data_valid = 0;
    step();
    chk("t1_single_push", 32'(count), 1);
    rd_ready = 1; step(); rd_ready = 0;
    chk("t1_popped", 32'(count), 0);

    // 2: fill, drop on full, drain in order
    fill(8'h00);
    chk("t2_full", 32'(full), 1);
    chk("t2_count16", 32'(count), 16);
    frame(8'hFF, 1);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_count_drop", 32'(count), 16);
    rd_ready = 1;
    for (int i = 0; i < int'(D); i++) begin
      chk("t2_order", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 0;
    chk("t2_empty", 32'(rd_valid), 0);

    // 3: push + pop while full
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("t3_ovf_cleared", 32'(overflow), 0);
    fill(8'h10);
    p_data = 8'h55; data_valid = 1; rd_ready = 1;
    step();
    data_valid = 0; rd_ready = 0;
    step();
    chk("t3_count", 32'(count), 16);
    chk("t3_overflow", 32'(overflow), 0);
    rd_ready = 1;
    for (int i = 0; i < 15; i++) begin
      chk("t3_order", 32'(rd_data), 32'h11 + 32'(i));
      step();
    end
    chk("t3_last", 32'(rd_data), 32'h55);
    step();
    rd_ready = 0;
    chk("t3_empty", 32'(rd_valid), 0);

    // 4: flush with coincident push, overflow preserved
    fill(8'h40);
    frame(8'hFF, 1);
    flush = 1; step(); flush = 0;
    chk("t4_flush_count", 32'(count), 0);
    frame(8'hC1, 1); frame(8'hC2, 1); frame(8'hC3, 1);
    chk("t4_count3", 32'(count), 3);
    p_data = 8'hC4; data_valid = 1; flush = 1;
    step();
    flush = 0;
    chk("t4_count0", 32'(count), 0);
    chk("t4_rd_valid", 32'(rd_valid), 0);
    chk("t4_ovf_kept", 32'(overflow), 1);
    step();
    chk("t4_no_late_push", 32'(count), 0);
    data_valid = 0;
    step();

    // 5: overflow set beats clear; clear alone clears
    fill(8'h60);
    p_data = 8'hEE; data_valid = 1; ovf_clr = 1;
    step();
    data_valid = 0; ovf_clr = 0;
    chk("t5_set_wins", 32'(overflow), 1);
    chk("t5_count", 32'(count), 16);
    step();
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("t5_cleared", 32'(overflow), 0);
    flush = 1; step(); flush = 0;

    // push + pop at count 1
    frame(8'h31, 1);
    p_data = 8'h32; data_valid = 1; rd_ready = 1;
    step();
    data_valid = 0; rd_ready = 0;
    chk("c1_count", 32'(count), 1);
    chk("c1_data", 32'(rd_data), 32'h32);
    step();
    flush = 1; step(); flush = 0;

    // reset mid-frame: held data_valid pushes again after release
    p_data = 8'h77; data_valid = 1;
    step();
    rst_n = 0; step();
    chk("rm_reset", 32'(count), 0);
    rst_n = 1; step();
    chk("rm_repush", 32'(count), 1);
    chk("rm_data", 32'(rd_data), 32'h77);
    data_valid = 0; step();
    flush = 1; step(); flush = 0;

    // 6: error counters
    repeat (3) begin par_err = 1; step(); par_err = 0; step(); end
    repeat (260) begin stp_err = 1; step(); stp_err = 0; step(); end
`ifdef UART_RX_ERR_CNT_EN
    chk("t6_par3", 32'(par_err_cnt), 3);
    chk("t6_stp_sat", 32'(stp_err_cnt), 255);
`else
    chk("t6_par_off", 32'(par_err_cnt), 0);
    chk("t6_stp_off", 32'(stp_err_cnt), 0);
`endif
    par_err = 1; ovf_clr = 1; step();
    par_err = 0; ovf_clr = 0; step();
    chk("t6_par_clr", 32'(par_err_cnt), 0);
    chk("t6_stp_clr", 32'(stp_err_cnt), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
